// File: rtl/vend_pkg.sv
// Shared constants for the vending-machine display: segment codes, converter
// states and the default scan divider.
package vend_pkg;

  localparam logic [15:0] SCAN_DIV_DEFAULT = 16'd50000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  // Active-low segments {a,b,c,d,e,f,g,dp}; dp is always dark
  localparam logic [7:0] SEG_0     = 8'b00000011;
  localparam logic [7:0] SEG_1     = 8'b10011111;
  localparam logic [7:0] SEG_2     = 8'b00100101;
  localparam logic [7:0] SEG_3     = 8'b00001101;
  localparam logic [7:0] SEG_4     = 8'b10011001;
  localparam logic [7:0] SEG_5     = 8'b01001001;
  localparam logic [7:0] SEG_6     = 8'b01000001;
  localparam logic [7:0] SEG_7     = 8'b00011111;
  localparam logic [7:0] SEG_8     = 8'b00000001;
  localparam logic [7:0] SEG_9     = 8'b00001001;
  localparam logic [7:0] SEG_R     = 8'b11110101;
  localparam logic [7:0] SEG_BLANK = 8'b11111111;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, 8 cycles per byte.
// bcd is only meaningful while done is high.
module bin2bcd_seq
  import vend_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state_q, state_d;
  logic [19:0] sh_q;
  logic [2:0]  cnt_q;

  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] s;
    s = v;
    if (s[11:8]  >= 4'd5) s[11:8]  = s[11:8]  + 4'd3;
    if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
    if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
    return {s[18:0], 1'b0};
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    if (cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          sh_q  <= {12'd0, bin};
          cnt_q <= '0;
        end
        CONV: begin
          sh_q  <= dabble_step(sh_q);
          cnt_q <= cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = sh_q[19:8];

endmodule

// File: rtl/vend_display.sv
// Four-digit multiplexed display for the vending machine: credit on the right
// three digits (leading zeros blanked), refund/stock status on the left digit.
module vend_display #(
  parameter logic [15:0] SCAN_DIV = vend_pkg::SCAN_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] money,
  input  logic       drop_tea,
  input  logic       drop_coke,
  input  logic       drop_sprite,
  input  logic       state,
  output logic [3:0] DIGIT,
  output logic [7:0] DISPLAY
);
  import vend_pkg::*;

  logic [7:0]  money_lat;
  logic        start;
  logic        conv_busy;
  logic        conv_done;
  logic [11:0] conv_bcd;
  logic [11:0] shown_bcd;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [1:0]  sel;
  logic [1:0]  drop_cnt;
  logic [3:0]  digit_d;
  logic [7:0]  seg_d;

  // New conversions only launch from idle, so an in-flight one is never disturbed
  assign start = !conv_busy && (money != money_lat);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (money),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      money_lat <= '0;
      shown_bcd <= '0;
    end else begin
      if (start) money_lat <= money;
      if (conv_done) shown_bcd <= conv_bcd;
    end
  end

  assign tick = (tick_cnt == SCAN_DIV - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      sel      <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      sel      <= sel + 2'd1;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  assign drop_cnt = {1'b0, ~drop_tea} + {1'b0, ~drop_coke} + {1'b0, ~drop_sprite};

  always_comb begin
    digit_d = 4'b1111;
    seg_d   = SEG_BLANK;
    case (sel)
      2'd0: begin
        digit_d = 4'b1110;
        seg_d   = seg_digit(shown_bcd[3:0]);
      end
      2'd1: begin
        digit_d = 4'b1101;
        seg_d   = (shown_bcd[11:4] == 8'h00) ? SEG_BLANK : seg_digit(shown_bcd[7:4]);
      end
      2'd2: begin
        digit_d = 4'b1011;
        seg_d   = (shown_bcd[11:8] == 4'h0) ? SEG_BLANK : seg_digit(shown_bcd[11:8]);
      end
      default: begin
        digit_d = 4'b0111;
        seg_d   = state ? SEG_R : seg_digit({2'b00, drop_cnt});
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      DIGIT   <= 4'b1111;
      DISPLAY <= SEG_BLANK;
    end else begin
      DIGIT   <= digit_d;
      DISPLAY <= seg_d;
    end
  end

endmodule

// File: tb/tb_vend_display.sv
// Self-checking bench for vend_display: directed scenarios plus random credit
// values checked against a decimal-arithmetic model of the display.
module tb_vend_display;

  localparam logic [15:0] SD = 16'd4;
  localparam logic [7:0] T_SEG_R = 8'b11110101;
  localparam logic [7:0] T_BLANK = 8'b11111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] money;
  logic       drop_tea, drop_coke, drop_sprite;
  logic       state;
  logic [3:0] DIGIT;
  logic [7:0] DISPLAY;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tab [0:9] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
                                8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
                                8'b00000001, 8'b00001001};
  logic [3:0] rot [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  vend_display #(.SCAN_DIV(SD)) dut (
    .clk         (clk),
    .rst         (rst),
    .money       (money),
    .drop_tea    (drop_tea),
    .drop_coke   (drop_coke),
    .drop_sprite (drop_sprite),
    .state       (state),
    .DIGIT       (DIGIT),
    .DISPLAY     (DISPLAY)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] m, input logic [2:0] drops, input logic st);
    money       = m;
    drop_tea    = drops[0];
    drop_coke   = drops[1];
    drop_sprite = drops[2];
    state       = st;
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  function automatic logic [11:0] toBcd(input int m);
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Expected segments for one display position from the decimal value of the credit
  function automatic logic [7:0] expSeg(input int pos, input int m, input logic st,
                                        input logic [2:0] drops);
    int h, t, o, nlow;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    nlow = 0;
    for (int b = 0; b < 3; b++) if (drops[b] == 1'b0) nlow++;
    case (pos)
      0:       return seg_tab[o];
      1:       return (h == 0 && t == 0) ? T_BLANK : seg_tab[t];
      2:       return (h == 0) ? T_BLANK : seg_tab[h];
      default: return st ? T_SEG_R : seg_tab[nlow];
    endcase
  endfunction

  // Waits for a fresh slot of the given position, bounded to two scan rounds
  task automatic waitDigitSlot(input int pos);
    int n;
    n = 0;
    while (DIGIT === rot[pos] && n < 2 * 4 * SD + 8) begin tick1(); n++; end
    while (DIGIT !== rot[pos] && n < 2 * 4 * SD + 8) begin tick1(); n++; end
    checkOutput("slot_reach", {28'd0, DIGIT}, {28'd0, rot[pos]});
  endtask

  task automatic scanCheck(input string tag, input int m, input logic st, input logic [2:0] drops);
    for (int p = 0; p < 4; p++) begin
      waitDigitSlot(p);
      checkOutput(tag, {24'd0, DISPLAY}, {24'd0, expSeg(p, m, st, drops)});
    end
  endtask

  initial begin
    int m;
    logic [2:0] d;
    logic st;

    applyStimulus(8'd0, 3'b111, 1'b0);
    rst = 1'b1;
    cycles(2);
    checkOutput("rst_digit", {28'd0, DIGIT}, 32'hF);
    checkOutput("rst_display", {24'd0, DISPLAY}, 32'hFF);
    checkOutput("rst_bcd", {20'd0, dut.shown_bcd}, 32'h000);

    // Scan rotation and idle converter straight out of reset
    rst = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      tick1();
      checkOutput("scan_digit", {28'd0, DIGIT}, {28'd0, rot[((n - 1) / 4) % 4]});
      checkOutput("scan_display", {24'd0, DISPLAY},
                  {24'd0, expSeg(((n - 1) / 4) % 4, 0, 1'b0, 3'b111)});
      checkOutput("no_conv", {31'd0, dut.conv_busy}, 32'd0);
    end

    // Ten-cycle latency for 0 -> 50
    applyStimulus(8'd50, 3'b111, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick1();
      checkOutput("lat50", {20'd0, dut.shown_bcd}, (k < 10) ? 32'h000 : 32'h050);
    end
    scanCheck("scan50", 50, 1'b0, 3'b111);

    applyStimulus(8'd255, 3'b111, 1'b0);
    cycles(11);
    checkOutput("bcd255", {20'd0, dut.shown_bcd}, {20'd0, toBcd(255)});
    scanCheck("scan255", 255, 1'b0, 3'b111);

    // Credit changes during the third conversion cycle
    applyStimulus(8'd15, 3'b111, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick1();
      if (k == 3) money = 8'd20;
      checkOutput("midconv", {20'd0, dut.shown_bcd},
                  (k < 10) ? 32'h255 : ((k < 20) ? 32'h015 : 32'h020));
    end

    applyStimulus(8'd20, 3'b000, 1'b0);
    waitDigitSlot(3);
    checkOutput("status3", {24'd0, DISPLAY}, {24'd0, expSeg(3, 20, 1'b0, 3'b000)});
    state = 1'b1;
    waitDigitSlot(3);
    checkOutput("status_r", {24'd0, DISPLAY}, {24'd0, T_SEG_R});

    // Reset in the middle of a conversion
    applyStimulus(8'd77, 3'b111, 1'b0);
    cycles(5);
    rst = 1'b1;
    tick1();
    checkOutput("abort_bcd", {20'd0, dut.shown_bcd}, 32'h000);
    checkOutput("abort_digit", {28'd0, DIGIT}, 32'hF);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick1();
      checkOutput("reconv77", {20'd0, dut.shown_bcd}, (k < 10) ? 32'h000 : {20'd0, toBcd(77)});
    end

    for (int i = 0; i < 6; i++) begin
      m  = int'($urandom_range(0, 255));
      d  = 3'($urandom_range(0, 7));
      st = 1'($urandom_range(0, 1));
      applyStimulus(8'(m), d, st);
      cycles(12);
      checkOutput("rand_bcd", {20'd0, dut.shown_bcd}, {20'd0, toBcd(m)});
      scanCheck("rand_scan", m, st, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_display.md
VEND_DISPLAY -- requirements
Module: vend_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd50000, giving clk cycles per digit-scan tick.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port money, input, 8: current credit in binary, unsigned.
REQ-005 SHALL have ports drop_tea, drop_coke and drop_sprite, input, 1 each: active-low "drink available" flags.
REQ-006 SHALL have port state, input, 1: 1 = refund in progress, 0 = normal.
REQ-007 SHALL have port DIGIT, output, 4: active-low digit enables, one-hot-low; bit0 is the rightmost digit.
REQ-008 SHALL have port DISPLAY, output, 8: active-low segments {a,b,c,d,e,f,g,dp} at bits [7:0].

Function
REQ-009 SHALL hold a snapshot register money_lat and a converter FSM with states IDLE, CONV and DONE.
REQ-010 In IDLE, when money != money_lat, SHALL copy money into money_lat and enter CONV.
REQ-011 CONV SHALL run a double-dabble conversion: exactly 8 shift cycles producing 3 BCD digits (hundreds, tens, ones); each nibble >=5 gets +3 before the shift.
REQ-012 DONE SHALL last 1 cycle, load the shown-BCD register atomically, then return to IDLE.
REQ-013 Latency from a money change to the shown-BCD update SHALL be 10 cycles: 1 IDLE + 8 CONV + 1 DONE.
REQ-014 A money change during CONV or DONE SHALL NOT disturb the conversion in flight; the IDLE compare then starts a new conversion on the next cycle.
REQ-015 The shown BCD value SHALL only ever hold fully converted snapshots, never intermediate values.
REQ-016 The tick counter SHALL count 0..SCAN_DIV-1, pulse tick at SCAN_DIV-1, then wrap to 0.
REQ-017 The 2-bit digit select SHALL increment on each tick, wrapping 3->0.
REQ-018 DIGIT SHALL be 1110 for sel0 (ones), 1101 for sel1 (tens), 1011 for sel2 (hundreds) and 0111 for sel3 (status).
REQ-019 Ones SHALL always be shown; hundreds SHALL be blank when 0; tens SHALL be blank when both hundreds and tens are 0.
REQ-020 The status digit SHALL show 'r' when state=1; otherwise it SHALL show the count of drop_* flags that are low (0..3).
REQ-021 Segment codes SHALL be: 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001, r=11110101, blank=11111111; dp SHALL always be off.
REQ-022 DIGIT and DISPLAY SHALL be registered and SHALL change together, one cycle after sel changes.
REQ-023 The state and drop_* inputs SHALL be sampled each cycle with no debounce.

Reset
REQ-024 When rst=1 at a clk edge, the block SHALL set DIGIT=1111, DISPLAY=11111111, tick counter=0, sel=0, FSM=IDLE, money_lat=0 and shown BCD=000.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no shown-BCD update.
REQ-026 After reset release with money=0, no conversion SHALL start, and the first tick SHALL show '0' on DIGIT=1110.

Structure
REQ-027 Package vend_pkg SHALL hold the segment code constants, the converter FSM state encoding and the default SCAN_DIV.
REQ-028 Sub-module bin2bcd_seq SHALL implement the converter, with ports clk, rst, start, bin[7:0], busy, done and bcd[11:0].
REQ-029 The scan counter, digit mux, blanking and status logic SHALL live in vend_display.

Verification
REQ-030 Reset with SCAN_DIV=4 -> DIGIT=1111 and DISPLAY=FF; after the first tick, DIGIT=1110 and DISPLAY=00000011.
REQ-031 money 0->50 -> shown BCD=050 exactly 10 cycles later; ones=00000011, tens=01001001, hundreds=11111111.
REQ-032 money=255 -> scan shows 5, 5, 2 (01001001, 01001001, 00100101) on sel0..2.
REQ-033 money changes 15->20 in the 3rd CONV cycle -> shown BCD goes 015 then 020 within 20 cycles, with no other value in between.
REQ-034 drop_*=000 with state=0 -> status digit 00001101 ('3'); state=1 -> 11110101 ('r') on the next sel3 slot.
REQ-035 Run 8 ticks with SCAN_DIV=4 -> DIGIT sequence 1110, 1101, 1011, 0111, 1110, ... with one update every 4 cycles.
